mem_port_arbiter: RTL and testbench

- Shares one 128-bit block memory port between the instruction cache and the data cache.
- Each cache keeps its own read/write/busywait block-transfer handshake. The arbiter serialises transfers and grants round-robin when both caches request together.
- Sits between icache/dcache and the unified block memory. It tags each transfer with a region bit so instruction and data blocks occupy separate halves of memory.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block-memory port between the icache and the
// dcache. Transfers are serialised, ties are granted round-robin, and every
// memory address carries a region bit (0 = instruction, 1 = data) on top.
module mem_port_arbiter #(
    parameter int BLK_AW = 6,
    parameter int BLK_W  = 128
) (
    input  logic              clock,
    input  logic              reset,
    // icache side
    input  logic              i_read,
    input  logic [BLK_AW-1:0] i_address,
    output logic [BLK_W-1:0]  i_readdata,
    output logic              i_busywait,
    // dcache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [BLK_AW-1:0] d_address,
    input  logic [BLK_W-1:0]  d_writedata,
    output logic [BLK_W-1:0]  d_readdata,
    output logic              d_busywait,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [BLK_AW:0]   mem_address,
    output logic [BLK_W-1:0]  mem_writedata,
    input  logic [BLK_W-1:0]  mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 0 = icache, 1 = dcache
    logic              started_q, started_d;
    logic [BLK_AW-1:0] addr_q, addr_d;
    logic [BLK_W-1:0]  wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [BLK_W-1:0]  i_hold_q, i_hold_d;
    logic [BLK_W-1:0]  d_hold_q, d_hold_d;

    logic i_req;
    logic d_req;
    logic granted;
    logic done;
    logic i_done;
    logic d_done;
    logic pick_d;

    // A dcache read+write together is treated as a write, so either strobe is a request.
    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign granted = (state_q != IDLE);

    // Memory raises busywait one edge after the strobe, so the first grant cycle
    // never completes. Reset aborts the transfer, so it also suppresses delivery.
    assign done   = granted && started_q && !mem_busywait && !reset;
    assign i_done = done && (state_q == GRANT_I);
    assign d_done = done && (state_q == GRANT_D);

    // On a tie the requester that was not granted last time wins.
    assign pick_d = d_req && (!i_req || !last_grant_q);

    // Next-state logic: arbitration in IDLE, completion tracking in the grant states.
    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        started_d    = started_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        i_hold_d     = i_hold_q;
        d_hold_d     = d_hold_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d      = pick_d ? GRANT_D : GRANT_I;
                    last_grant_d = pick_d;
                    started_d    = 1'b0;
                    addr_d       = pick_d ? d_address : i_address;
                    wdata_d      = pick_d ? d_writedata : '0;
                    write_d      = pick_d && d_write;
                end
            end
            GRANT_I, GRANT_D: begin
                started_d = 1'b1;
                if (i_done) begin
                    i_hold_d = mem_readdata;
                end
                if (d_done && !write_q) begin
                    d_hold_d = mem_readdata;
                end
                if (done) begin
                    // Always pass through IDLE so the requester can drop its strobe.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and delivered-data holds, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            started_q    <= 1'b0;
            i_hold_q     <= '0;
            d_hold_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            started_q    <= started_d;
            i_hold_q     <= i_hold_d;
            d_hold_q     <= d_hold_d;
        end
    end

    // Latched transfer descriptor for the current owner.
    always_ff @(posedge clock) begin
        // NOTE: these are deliberately not reset: they are only observed in a
        // grant state, which can only be entered after IDLE has loaded them.
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        write_q <= write_d;
    end

    // Memory strobes, per-cache stalls and returned blocks.
    always_comb begin
        mem_read      = granted && !write_q;
        mem_write     = granted && write_q;
        mem_address   = '0;
        mem_writedata = '0;
        if (granted) begin
            mem_address   = {(state_q == GRANT_D), addr_q};
            mem_writedata = wdata_q;
        end

        i_busywait = i_req && !i_done;
        d_busywait = d_req && !d_done;

        i_readdata = i_done ? mem_readdata : i_hold_q;
        d_readdata = (d_done && !write_q) ? mem_readdata : d_hold_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives icache/dcache block transfers against a small
// latency-programmable memory model. Expected transfers are queued per cache
// when requested and compared when that cache is released.
module tb_mem_port_arbiter;

    localparam int AW = 6;
    localparam int W  = 128;

    typedef struct {
        logic         wr;
        logic [AW:0]  addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
        int           lat;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [W-1:0]  i_readdata;
    logic          i_busywait;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [W-1:0]  d_writedata;
    logic [W-1:0]  d_readdata;
    logic          d_busywait;
    logic          mem_read;
    logic          mem_write;
    logic [AW:0]   mem_address;
    logic [W-1:0]  mem_writedata;
    logic [W-1:0]  mem_readdata;
    logic          mem_busywait;

    mem_port_arbiter #(.BLK_AW(AW), .BLK_W(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_readdata   (i_readdata),
        .i_busywait   (i_busywait),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_writedata  (d_writedata),
        .d_readdata   (d_readdata),
        .d_busywait   (d_busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Initial memory contents; address 0x05 holds the recognisable block.
    function automatic logic [W-1:0] pattern(input logic [AW:0] a);
        if (a == 7'h05) return 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_0000_0001;
        return {4{32'h5A00_0000 | {25'h0, a}}};
    endfunction

    // ---------------- memory model ----------------
    int           mem_lat;           // busywait-high cycles per transfer
    logic [W-1:0] mem_data [128];
    bit           mem_wr_vld [128];
    logic         m_active;
    int           m_cnt;

    assign mem_readdata = mem_wr_vld[mem_address] ? mem_data[mem_address] : pattern(mem_address);

    always @(posedge clock) begin
        if (reset) begin
            m_active     <= 1'b0;
            mem_busywait <= 1'b0;
            m_cnt        <= 0;
        end else if ((mem_read || mem_write) && !m_active) begin
            m_active     <= 1'b1;
            m_cnt        <= mem_lat;
            mem_busywait <= (mem_lat > 0);
            if (mem_write) begin
                mem_data[mem_address]   <= mem_writedata;
                mem_wr_vld[mem_address] <= 1'b1;
            end
        end else if (m_active && (mem_read || mem_write)) begin
            if (mem_busywait) begin
                if (m_cnt <= 1) mem_busywait <= 1'b0;
                m_cnt <= m_cnt - 1;
            end
        end else begin
            m_active     <= 1'b0;
            mem_busywait <= 1'b0;
        end
    end

    // ---------------- scoreboard state ----------------
    int           total = 0;
    int           bad   = 0;
    exp_t         iq[$];
    exp_t         dq[$];
    logic [W-1:0] ref_mem [128];
    bit           ref_vld [128];
    logic [W-1:0] i_hold_exp;
    logic [W-1:0] d_hold_exp;
    int           i_done_cyc;
    int           d_done_cyc;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_rd(input logic [AW:0] a);
        return ref_vld[a] ? ref_mem[a] : pattern(a);
    endfunction

    // Pops and compares whenever a cache is released by the arbiter.
    task automatic monitor();
        logic strobe;
        logic prev_strobe = 1'b0;
        int   gstart = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            strobe = mem_read | mem_write;
            if (strobe && !prev_strobe) gstart = cyc;
            prev_strobe = strobe;
            if (!reset && i_read && !i_busywait) begin
                i_done_cyc = cyc;
                check("i_pending", iq.size() > 0, 1'b1);
                if (iq.size() > 0) begin
                    e = iq.pop_front();
                    check("i_addr", mem_address, e.addr);
                    check("i_rdstrobe", mem_read, 1'b1);
                    check("i_data", i_readdata, e.rdata);
                    check("i_lat", 128'(cyc - gstart + 1), 128'(e.lat));
                    if (d_read | d_write) check("d_stalled", d_busywait, 1'b1);
                end
            end
            if (!reset && (d_read || d_write) && !d_busywait) begin
                d_done_cyc = cyc;
                check("d_pending", dq.size() > 0, 1'b1);
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    check("d_addr", mem_address, e.addr);
                    check("d_wrstrobe", mem_write, e.wr);
                    check("d_rdstrobe", mem_read, !e.wr);
                    if (e.wr) check("d_wdata", mem_writedata, e.wdata);
                    check("d_data", d_readdata, e.rdata);
                    check("d_lat", 128'(cyc - gstart + 1), 128'(e.lat));
                    if (i_read) check("i_stalled", i_busywait, 1'b1);
                end
            end
        end
    endtask

    // Full icache read; optionally changes the address mid-grant.
    task automatic i_xfer(input logic [AW-1:0] a, input bit chg);
        exp_t e;
        bit   ok = 0;
        e.wr = 1'b0; e.addr = {1'b0, a}; e.wdata = '0;
        e.rdata = ref_rd({1'b0, a}); e.lat = mem_lat + 2;
        iq.push_back(e);
        i_hold_exp = e.rdata;
        @(posedge clock); #1;
        i_read = 1'b1; i_address = a;
        if (chg) begin
            repeat (3) @(negedge clock);
            i_address = 6'h02;
        end
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            if (!i_busywait) ok = 1;
        end
        check("i_release", ok, 1'b1);
        @(posedge clock); #1;
        i_read = 1'b0;
        @(negedge clock);
        check("i_hold", i_readdata, i_hold_exp);
        check("i_bw_idle", i_busywait, 1'b0);
    endtask

    // Full dcache transfer; rd and wr both high must behave as a write.
    task automatic d_xfer(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [W-1:0] wd);
        exp_t e;
        bit   ok = 0;
        e.wr = wr; e.addr = {1'b1, a}; e.wdata = wd; e.lat = mem_lat + 2;
        if (wr) begin
            e.rdata = d_hold_exp;
            ref_mem[{1'b1, a}] = wd;
            ref_vld[{1'b1, a}] = 1'b1;
        end else begin
            e.rdata = ref_rd({1'b1, a});
            d_hold_exp = e.rdata;
        end
        dq.push_back(e);
        @(posedge clock); #1;
        d_read = rd; d_write = wr; d_address = a; d_writedata = wd;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            if (!d_busywait) ok = 1;
        end
        check("d_release", ok, 1'b1);
        @(posedge clock); #1;
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clock);
        check("d_hold", d_readdata, d_hold_exp);
        check("d_bw_idle", d_busywait, 1'b0);
    endtask

    initial begin
        exp_t e;
        bit   ok;
        reset = 1'b1; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
        mem_lat = 4; i_hold_exp = '0; d_hold_exp = '0;
        i_done_cyc = 0; d_done_cyc = 0;
        fork monitor(); join_none
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_address, '0);
        check("rst_i_bw", i_busywait, 1'b0);
        check("rst_d_bw", d_busywait, 1'b0);
        check("rst_i_data", i_readdata, '0);
        check("rst_d_data", d_readdata, '0);

        // Single icache read, busy for 4 cycles after the strobe.
        mem_lat = 4;
        i_xfer(6'h05, 1'b0);

        // dcache write-back to the top block, then read it back with no busy.
        mem_lat = 2;
        d_xfer(1'b0, 1'b1, 6'h3F, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
        mem_lat = 0;
        d_xfer(1'b1, 1'b0, 6'h3F, '0);

        // First tie after reset: icache first, dcache after one idle cycle.
        mem_lat = 1;
        fork
            i_xfer(6'h0A, 1'b0);
            d_xfer(1'b1, 1'b0, 6'h0B, '0);
        join
        check("tie1_order", 128'(d_done_cyc - i_done_cyc), 128'(mem_lat + 3));

        // Lone icache read with an address change mid-grant; last grant is now I.
        mem_lat = 3;
        i_xfer(6'h01, 1'b1);

        // Second tie: dcache first.
        mem_lat = 2;
        fork
            i_xfer(6'h0C, 1'b0);
            d_xfer(1'b1, 1'b0, 6'h0D, '0);
        join
        check("tie2_order", 128'(i_done_cyc - d_done_cyc), 128'(mem_lat + 3));

        // Read and write together act as a write; confirm with a read-back.
        mem_lat = 1;
        d_xfer(1'b1, 1'b1, 6'h20, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        d_xfer(1'b1, 1'b0, 6'h20, '0);

        // Reset in the third grant cycle of a dcache read.
        mem_lat = 6;
        e.wr = 1'b0; e.addr = {1'b1, 6'h10}; e.wdata = '0;
        e.rdata = ref_rd({1'b1, 6'h10}); e.lat = mem_lat + 2;
        dq.push_back(e);
        @(posedge clock); #1;
        d_read = 1'b1; d_address = 6'h10;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            if (mem_read) ok = 1;
        end
        check("rst_grant_seen", ok, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_mem_read", mem_read, 1'b0);
        check("abort_mem_write", mem_write, 1'b0);
        check("abort_d_hold", d_readdata, '0);
        check("abort_i_hold", i_readdata, '0);
        check("abort_d_bw", d_busywait, 1'b1);
        reset = 1'b0;
        d_hold_exp = e.rdata;
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            if (!d_busywait) ok = 1;
        end
        check("regrant_release", ok, 1'b1);
        @(posedge clock); #1;
        d_read = 1'b0;
        @(negedge clock);
        check("regrant_hold", d_readdata, d_hold_exp);
        check("queues_empty", 128'(iq.size() + dq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
